// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory handshake FSM, WB/redirect outputs.
// Optional MEM_STAGE_MISALIGN_TRAP_EN adds misalign_err trap on [1:0]!=0.
// Ports: CLK/RESET; EX side *E/*_in + valid_in; mem_req/we/addr/wdata,
//   mem_ack/rdata; WB side *M, valid_M, PCSrcM/PCTargetM, stall_out.
module mem_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [5:0]  ALUopE,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] WriteData_in,
  input  logic [31:0] PCPlus4_in,
  input  logic [31:0] PCBranch_in,
  input  logic [4:0]  wb_addr_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        valid_M,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [5:0]  ALUopM,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  wb_addrM,
  output logic        PCSrcM,
  output logic [31:0] PCTargetM,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        stall_out
);

  typedef enum logic [1:0] {
    IDLE, PASS, ACCESS, DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_RegWrite;
  logic        r_MemtoReg;
  logic        r_MemWrite;
  logic        r_Branch;
  logic        r_Jump;
  logic [5:0]  r_ALUop;
  logic [31:0] r_ALUOut;
  logic [31:0] r_WriteData;
  logic [31:0] r_PCPlus4;
  logic [31:0] r_PCBranch;
  logic [31:0] r_ReadData;
  logic [4:0]  r_wb_addr;

  logic        w_cap;
  logic        w_mem;
  logic        w_mis;
  logic        w_acc;

  assign w_acc = (r_state == ACCESS);
  assign w_cap = valid_in && !w_acc;
  assign w_mem = MemtoRegE || MemWriteE;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = w_mem && (ALUOut_in[1:0] != 2'b00);
  assign misalign_err = r_mis;

  // Sticky until reset so software can poll after the fact.
  always_ff @(posedge CLK) begin
    if (RESET)
      r_mis <= 1'b0;
    else if (w_cap && w_mis)
      r_mis <= 1'b1;
  end
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, PASS, DONE: begin
        if (w_cap)
          w_next = (w_mem && !w_mis) ? ACCESS : PASS;
        else
          w_next = IDLE;
      end
      ACCESS: begin
        if (mem_ack)
          w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_RegWrite  <= 1'b0;
      r_MemtoReg  <= 1'b0;
      r_MemWrite  <= 1'b0;
      r_Branch    <= 1'b0;
      r_Jump      <= 1'b0;
      r_ALUop     <= '0;
      r_ALUOut    <= '0;
      r_WriteData <= '0;
      r_PCPlus4   <= '0;
      r_PCBranch  <= '0;
      r_wb_addr   <= '0;
    end else if (w_cap) begin
      // A trapped access must not write back.
      r_RegWrite  <= RegWriteE && !w_mis;
      r_MemtoReg  <= MemtoRegE;
      r_MemWrite  <= MemWriteE;
      r_Branch    <= BranchE;
      r_Jump      <= JumpE;
      r_ALUop     <= ALUopE;
      r_ALUOut    <= ALUOut_in;
      r_WriteData <= WriteData_in;
      r_PCPlus4   <= PCPlus4_in;
      r_PCBranch  <= PCBranch_in;
      r_wb_addr   <= wb_addr_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_ReadData <= '0;
    else if (w_acc && mem_ack && r_MemtoReg)
      r_ReadData <= mem_rdata;
  end

  assign stall_out = w_acc;
  assign mem_req   = w_acc;
  assign mem_we    = w_acc && r_MemWrite;
  assign mem_addr  = w_acc ? {r_ALUOut[31:2], 2'b00} : 32'd0;
  assign mem_wdata = w_acc ? r_WriteData : 32'd0;

  assign valid_M   = (r_state == PASS) || (r_state == DONE);
  assign RegWriteM = valid_M && r_RegWrite;
  assign MemtoRegM = r_MemtoReg;
  assign ALUopM    = r_ALUop;
  assign ALUOutM   = r_ALUOut;
  assign ReadDataM = r_ReadData;
  assign PCPlus4M  = r_PCPlus4;
  assign wb_addrM  = r_wb_addr;

  assign PCSrcM    = valid_M &&
                     ((r_Branch && (r_ALUOut == 32'd1)) || r_Jump);
  assign PCTargetM = r_Branch ? r_PCBranch : r_ALUOut;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Expected values come from an instruction-level model of the stage.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        valid_in;
  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE;
  logic [5:0]  ALUopE;
  logic [31:0] ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in;
  logic [4:0]  wb_addr_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        valid_M, RegWriteM, MemtoRegM;
  logic [5:0]  ALUopM;
  logic [31:0] ALUOutM, ReadDataM, PCPlus4M;
  logic [4:0]  wb_addrM;
  logic        PCSrcM;
  logic [31:0] PCTargetM;
  logic        stall_out;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = 32'd0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUopE(ALUopE), .ALUOut_in(ALUOut_in),
    .WriteData_in(WriteData_in), .PCPlus4_in(PCPlus4_in),
    .PCBranch_in(PCBranch_in), .wb_addr_in(wb_addr_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_M(valid_M), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ALUopM(ALUopM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .wb_addrM(wb_addrM), .PCSrcM(PCSrcM),
    .PCTargetM(PCTargetM),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .stall_out(stall_out)
  );

  typedef struct {
    logic        rw, m2r, mw, br, jp;
    logic [5:0]  op;
    logic [31:0] alu, wd, pc4, pcb;
    logic [4:0]  wa;
  } ins_t;

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jump
  function automatic ins_t rand_ins(input int k);
    ins_t t;
    t.op  = 6'($urandom);
    t.alu = $urandom;
    t.wd  = $urandom;
    t.pc4 = $urandom;
    t.pcb = $urandom;
    t.wa  = 5'($urandom);
    t.rw  = 1'($urandom_range(0, 1));
    t.m2r = 1'b0;
    t.mw  = 1'b0;
    t.br  = 1'b0;
    t.jp  = 1'b0;
    case (k)
      1: begin t.m2r = 1'b1; t.rw = 1'b1; t.alu[1:0] = 2'b00; end
      2: begin t.mw = 1'b1; t.rw = 1'b0; t.alu[1:0] = 2'b00; end
      3: begin
        t.br = 1'b1;
        t.rw = 1'b0;
        t.alu = 32'($urandom_range(0, 2));
      end
      4: t.jp = 1'b1;
      default: ;
    endcase
    return t;
  endfunction

  task automatic drive(input ins_t t, input logic v);
    valid_in     = v;
    RegWriteE    = t.rw;
    MemtoRegE    = t.m2r;
    MemWriteE    = t.mw;
    BranchE      = t.br;
    JumpE        = t.jp;
    ALUopE       = t.op;
    ALUOut_in    = t.alu;
    WriteData_in = t.wd;
    PCPlus4_in   = t.pc4;
    PCBranch_in  = t.pcb;
    wb_addr_in   = t.wa;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    drive(rand_ins(1), 1'b1);
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    tick;
    tick;
    checks++;
    if ({valid_M, RegWriteM, MemtoRegM, ALUopM, ALUOutM, ReadDataM,
         PCPlus4M, wb_addrM, PCSrcM, PCTargetM, stall_out,
         mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset: outputs not all zero (valid_M=%b stall=%b req=%b ALUOutM=%h)",
               valid_M, stall_out, mem_req, ALUOutM);
    end
    RESET = 1'b0;
    mem_ack = 1'b0;
    valid_in = 1'b0;
    exp_rd = 32'd0;
    tick;
  endtask

  task automatic test_back_to_back;
    ins_t t;
    for (int i = 0; i < 3; i++) begin
      t = rand_ins(0);
      drive(t, 1'b1);
      tick;
      checks++;
      if ({valid_M, stall_out, mem_req, RegWriteM, ALUOutM, wb_addrM} !==
          {1'b1, 1'b0, 1'b0, t.rw, t.alu, t.wa}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b st=%b rq=%b rw=%b alu=%h, need 1 0 0 %b %h",
                 i, valid_M, stall_out, mem_req, RegWriteM, ALUOutM, t.rw, t.alu);
      end
    end
    valid_in = 1'b0;
    tick;
    checks++;
    if ({valid_M, RegWriteM} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: valid_M=%b RegWriteM=%b need 0 0", valid_M, RegWriteM);
    end
  endtask

  task automatic test_load_wait;
    ins_t t;
    t = rand_ins(1);
    t.alu = 32'h0000_0104;
    drive(t, 1'b1);
    tick;
    drive(rand_ins(0), 1'b0);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({mem_req, mem_we, stall_out, valid_M, mem_addr} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0104}) begin
        errors++;
        $display("FAIL load_wait[%0d]: req=%b we=%b st=%b v=%b addr=%h need 1 0 1 0 00000104",
                 c, mem_req, mem_we, stall_out, valid_M, mem_addr);
      end
      if (c == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      tick;
    end
    mem_ack = 1'b0;
    exp_rd = 32'hDEAD_BEEF;
    checks++;
    if ({ReadDataM, valid_M, RegWriteM, stall_out} !== {exp_rd, 3'b110}) begin
      errors++;
      $display("FAIL load_done: rd=%h v=%b rw=%b st=%b need deadbeef 1 1 0",
               ReadDataM, valid_M, RegWriteM, stall_out);
    end
    tick;
    checks++;
    if ({valid_M, RegWriteM, ReadDataM} !== {2'b00, exp_rd}) begin
      errors++;
      $display("FAIL load_after: v=%b rw=%b rd=%h need 0 0 %h",
               valid_M, RegWriteM, ReadDataM, exp_rd);
    end
  endtask

  task automatic test_store;
    ins_t t;
    t = rand_ins(2);
    t.wd = 32'h1234_5678;
    drive(t, 1'b1);
    tick;
    valid_in = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_wdata, mem_addr} !==
        {2'b11, 32'h1234_5678, t.alu}) begin
      errors++;
      $display("FAIL store_acc: req=%b we=%b wd=%h addr=%h need 1 1 12345678 %h",
               mem_req, mem_we, mem_wdata, mem_addr, t.alu);
    end
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    tick;
    mem_ack = 1'b0;
    checks++;
    if ({valid_M, RegWriteM, mem_req, ReadDataM} !== {3'b100, exp_rd}) begin
      errors++;
      $display("FAIL store_done: v=%b rw=%b rq=%b rd=%h need 1 0 0 %h",
               valid_M, RegWriteM, mem_req, ReadDataM, exp_rd);
    end
    tick;
  endtask

  task automatic test_branch;
    ins_t t;
    logic es;
    logic [31:0] et;
    for (int i = 0; i < 12; i++) begin
      t = rand_ins(i < 3 ? 3 : 3 + (i % 2));
      if (i == 0) begin t.alu = 32'd1; t.pcb = 32'h40; end
      if (i == 1) begin t.alu = 32'd0; t.pcb = 32'h40; end
      if (i == 2) begin t = rand_ins(4); t.alu = 32'h0040_0000; end
      es = (t.br && t.alu == 32'd1) || t.jp;
      et = t.br ? t.pcb : t.alu;
      drive(t, 1'b1);
      tick;
      valid_in = 1'b0;
      checks++;
      if ({valid_M, PCSrcM, PCTargetM} !== {1'b1, es, et}) begin
        errors++;
        $display("FAIL branch[%0d]: v=%b src=%b tgt=%h need 1 %b %h",
                 i, valid_M, PCSrcM, PCTargetM, es, et);
      end
      tick;
      checks++;
      if (PCSrcM !== 1'b0) begin
        errors++;
        $display("FAIL branch_once[%0d]: PCSrcM=%b need 0", i, PCSrcM);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    drive(rand_ins(1), 1'b1);
    tick;
    valid_in = 1'b0;
    tick;
    RESET = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    tick;
    RESET = 1'b0;
    exp_rd = 32'd0;
    checks++;
    if ({mem_req, stall_out, valid_M, ReadDataM} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid: rq=%b st=%b v=%b rd=%h need 0 0 0 0",
               mem_req, stall_out, valid_M, ReadDataM);
    end
    mem_rdata = $urandom;
    tick;
    mem_ack = 1'b0;
    checks++;
    if ({ReadDataM, valid_M} !== {exp_rd, 1'b0}) begin
      errors++;
      $display("FAIL rst_late_ack: rd=%h v=%b need %h 0", ReadDataM, valid_M, exp_rd);
    end
  endtask

  task automatic test_ack_outside;
    drive(rand_ins(0), 1'b1);
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    tick;
    valid_in = 1'b0;
    checks++;
    if ({ReadDataM, valid_M, stall_out} !== {exp_rd, 2'b10}) begin
      errors++;
      $display("FAIL ack_outside: rd=%h v=%b st=%b need %h 1 0",
               ReadDataM, valid_M, stall_out, exp_rd);
    end
    mem_ack = 1'b0;
    tick;
  endtask

  task automatic test_random_stream;
    ins_t t;
    int k, w;
    logic [31:0] rd;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 4);
      t = rand_ins(k);
      drive(t, 1'b1);
      tick;
      drive(rand_ins(0), 1'b0);
      if (t.m2r || t.mw) begin
        w = $urandom_range(1, 4);
        rd = $urandom;
        for (int c = 1; c <= w; c++) begin
          checks++;
          if ({mem_req, mem_we, stall_out, valid_M, mem_addr, mem_wdata} !==
              {1'b1, t.mw, 1'b1, 1'b0, t.alu, t.wd}) begin
            errors++;
            $display("FAIL rnd_acc[%0d.%0d]: rq=%b we=%b st=%b v=%b a=%h wd=%h need we=%b a=%h wd=%h",
                     n, c, mem_req, mem_we, stall_out, valid_M, mem_addr,
                     mem_wdata, t.mw, t.alu, t.wd);
          end
          mem_ack = (c == w);
          mem_rdata = rd;
          tick;
        end
        mem_ack = 1'b0;
        if (t.m2r) exp_rd = rd;
      end
      checks++;
      if ({valid_M, stall_out, mem_req, RegWriteM, MemtoRegM, ALUopM,
           ALUOutM, PCPlus4M, wb_addrM, ReadDataM, PCSrcM, PCTargetM} !==
          {3'b100, t.rw, t.m2r, t.op, t.alu, t.pc4, t.wa, exp_rd,
           (t.br && t.alu == 32'd1) || t.jp, t.br ? t.pcb : t.alu}) begin
        errors++;
        $display("FAIL rnd_out[%0d]: v=%b rw=%b alu=%h pc4=%h rd=%h src=%b tgt=%h need rw=%b alu=%h pc4=%h rd=%h",
                 n, valid_M, RegWriteM, ALUOutM, PCPlus4M, ReadDataM, PCSrcM,
                 PCTargetM, t.rw, t.alu, t.pc4, exp_rd);
      end
      if ($urandom_range(0, 2) == 0) begin
        tick;
        checks++;
        if ({valid_M, RegWriteM, PCSrcM} !== 3'b000) begin
          errors++;
          $display("FAIL rnd_gap[%0d]: v=%b rw=%b src=%b need 0 0 0",
                   n, valid_M, RegWriteM, PCSrcM);
        end
      end
    end
    tick;
  endtask

  task automatic test_misalign;
    ins_t t;
    t = rand_ins(1);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    t.alu = 32'h0000_0102;
    drive(t, 1'b1);
    tick;
    valid_in = 1'b0;
    checks++;
    if ({mem_req, stall_out, valid_M, RegWriteM, misalign_err} !== 5'b00101) begin
      errors++;
      $display("FAIL misalign: rq=%b st=%b v=%b rw=%b err=%b need 0 0 1 0 1",
               mem_req, stall_out, valid_M, RegWriteM, misalign_err);
    end
    tick;
    tick;
    checks++;
    if ({misalign_err, mem_req} !== 2'b10) begin
      errors++;
      $display("FAIL misalign_hold: err=%b rq=%b need 1 0", misalign_err, mem_req);
    end
`else
    t.alu = 32'h0000_0107;
    drive(t, 1'b1);
    tick;
    valid_in = 1'b0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0104}) begin
      errors++;
      $display("FAIL misalign_ignored: rq=%b a=%h need 1 00000104",
               mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    exp_rd = mem_rdata;
    tick;
    mem_ack = 1'b0;
    checks++;
    if ({valid_M, RegWriteM, ReadDataM} !== {2'b11, exp_rd}) begin
      errors++;
      $display("FAIL misalign_done: v=%b rw=%b rd=%h need 1 1 %h",
               valid_M, RegWriteM, ReadDataM, exp_rd);
    end
    tick;
`endif
  endtask

  initial begin
    RESET = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(rand_ins(0), 1'b0);
    test_reset;
    test_back_to_back;
    test_load_wait;
    test_store;
    test_branch;
    test_ack_outside;
    test_random_stream;
    test_reset_mid_access;
    test_random_stream;
    test_misalign;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK input 1 (clock); RESET input 1 (synchronous reset, active high).
REQ-002 SHALL have the EX-side inputs:
- valid_in input 1: EX holds an instruction.
- RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE input 1 each.
- ALUopE input 6.
- ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in input 32 each.
- wb_addr_in input 5.
REQ-003 SHALL have the memory-side ports:
- mem_req output 1.
- mem_we output 1.
- mem_addr output 32.
- mem_wdata output 32.
- mem_ack input 1: one-cycle completion.
- mem_rdata input 32: valid when mem_ack=1.
REQ-004 SHALL have the WB-side and control outputs:
- valid_M output 1.
- RegWriteM, MemtoRegM output 1 each.
- ALUopM output 6.
- ALUOutM, ReadDataM, PCPlus4M output 32 each.
- wb_addrM output 5.
- PCSrcM output 1: redirect fetch.
- PCTargetM output 32.
- stall_out output 1: EX must hold its inputs.

Function
REQ-005 SHALL contain an EX/MEM register that captures all REQ-002 inputs at a CLK edge where valid_in=1 and stall_out=0. The register SHALL hold its contents otherwise.
REQ-006 SHALL implement the FSM {IDLE, PASS, ACCESS, DONE}:
- A captured instruction with MemtoRegE=1 or MemWriteE=1 goes to ACCESS.
- Any other captured instruction goes to PASS.
- PASS or DONE with no capture goes to IDLE.
- ACCESS with mem_ack=1 goes to DONE.
- ACCESS with mem_ack=0 stays in ACCESS.
REQ-007 SHALL drive stall_out=1 exactly while the FSM is in ACCESS. Captures are permitted in IDLE, PASS and DONE, giving back-to-back throughput for non-memory instructions.
REQ-008 SHALL, in ACCESS, drive the memory port as follows:
- mem_req=1.
- mem_we=MemWriteM.
- mem_addr={ALUOutM[31:2],2'b00}.
- mem_wdata=WriteDataM.
These values SHALL stay stable until and including the mem_ack cycle. Outside ACCESS, mem_req=0 and mem_we=0.
REQ-009 SHALL, for a load, latch mem_rdata into ReadDataM on the mem_ack edge. ReadDataM SHALL be unchanged by stores and by non-memory instructions.
REQ-010 SHALL assert valid_M=1 for exactly one cycle per instruction: in PASS for non-memory instructions and in DONE for memory instructions.
REQ-011 SHALL gate RegWriteM with valid_M, so a held register never produces a duplicate write-back.
REQ-012 SHALL compute the fetch redirect as follows:
- PCSrcM = valid_M & ((BranchM & ALUOutM==32'd1) | JumpM).
- PCTargetM = PCBranchM when BranchM=1, otherwise ALUOutM.
REQ-013 SHALL ignore mem_ack outside ACCESS.
REQ-014 SHALL pass ALUopM, ALUOutM, PCPlus4M, wb_addrM and MemtoRegM directly from the register, so jal write-back ($ra, PC+4) is unaffected by this stage.

Reset
REQ-015 SHALL, on a CLK edge with RESET=1, set the FSM to IDLE and clear every register, so all outputs read 0. This applies in every state, including ACCESS, and mem_req SHALL be 0 in the cycle after the edge.
REQ-016 SHALL ignore valid_in and mem_ack on a reset edge.

Configuration
REQ-017 SHALL support the macro MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: a memory instruction with ALUOut_in[1:0]!=0 is captured into PASS instead of ACCESS and issues no mem_req. Its RegWriteM is forced to 0. The output misalign_err (1 bit) is set and stays set until RESET.
- Undefined: the port misalign_err is absent and address bits [1:0] are ignored, per REQ-008.

Verification
REQ-018 Non-memory back-to-back: three valid ALU instructions on consecutive cycles -> valid_M=1 for three consecutive cycles, stall_out=0 throughout, mem_req=0.
REQ-019 Load with a 3-cycle wait: lw with ALUOut_in=0x00000104, mem_ack asserted on the third ACCESS cycle with mem_rdata=0xDEADBEEF:
- mem_req=1 and mem_addr=0x00000104 for three cycles.
- stall_out=1 for three cycles.
- The next cycle has ReadDataM=0xDEADBEEF, valid_M=1 and RegWriteM=1.
REQ-020 Store with same-cycle ack: sw with WriteData_in=0x12345678, mem_ack on the first ACCESS cycle -> mem_we=1, mem_wdata=0x12345678, then one DONE cycle with RegWriteM=0.
REQ-021 Branches and jump:
- beq with ALUOut_in=1 and PCBranch_in=0x00000040 -> PCSrcM=1 and PCTargetM=0x00000040 for one cycle.
- The same instruction with ALUOut_in=0 -> PCSrcM=0.
- j with ALUOut_in=0x00400000 -> PCTargetM=0x00400000.
REQ-022 Reset mid-ACCESS: RESET=1 during the second wait cycle -> mem_req=0, stall_out=0, valid_M=0 the next cycle. A later mem_ack produces no ReadDataM change.
REQ-023 With MEM_STAGE_MISALIGN_TRAP_EN, lw with ALUOut_in=0x00000102 -> no mem_req, misalign_err=1 held, RegWriteM=0.
